// File: rtl/cbrt_pkg.sv
// -----------------------------------------------------------------------------
// cbrt_pkg
// Shared types and helpers for the iterative integer cube root unit.
//   state_t     : FSM state encoding (IDLE, CALC, FIN)
//   cbrt_root_w : root width (and iteration count) for a given radicand width
// -----------------------------------------------------------------------------
package cbrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // ceil(w/3): number of root bits needed to cover a w-bit radicand
    function automatic int unsigned cbrt_root_w(input int unsigned w);
        return (w + 32'd2) / 32'd3;
    endfunction

endpackage : cbrt_pkg

// File: rtl/cbrt_iter_if.sv
// -----------------------------------------------------------------------------
// cbrt_iter_if
// Request/result bundle for the cube root unit.
//   start     : request, honoured only while the unit is idle
//   x         : W-bit unsigned radicand
//   root      : R-bit floor(cbrt(x)), valid while done=1
//   remainder : W-bit x - root^3, valid while done=1
//   busy      : unit is working on a request
//   done      : one-cycle result strobe
// master = requester, slave = cube root unit.
// -----------------------------------------------------------------------------
interface cbrt_iter_if
    import cbrt_pkg::*;
#(
    parameter int unsigned W = 8
);
    localparam int unsigned R = cbrt_root_w(W);

    logic         start;
    logic [W-1:0] x;
    logic [R-1:0] root;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output x,
        input  root,
        input  remainder,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  x,
        output root,
        output remainder,
        output busy,
        output done
    );

endinterface : cbrt_iter_if

// File: rtl/cbrt_iter_int_cube.sv
// -----------------------------------------------------------------------------
// int_cube
// Combinational cube of an R-bit unsigned value at full 3R-bit width.
//   i_a    : R-bit operand
//   o_cube : 3R-bit i_a^3, never truncated
// -----------------------------------------------------------------------------
module int_cube #(
    parameter int unsigned R = 3
) (
    input  logic [R-1:0]   i_a,
    output logic [3*R-1:0] o_cube
);
    localparam int unsigned CW = 3 * R;

    logic [CW-1:0] w_a_ext;

    assign w_a_ext = CW'(i_a);
    assign o_cube  = w_a_ext * w_a_ext * w_a_ext;

endmodule : int_cube

// File: rtl/cbrt_iter.sv
// -----------------------------------------------------------------------------
// cbrt_iter
// Iterative integer cube root: root = floor(cbrt(x)), remainder = x - root^3.
// Decides one root bit per cycle, MSB first; latency R+1 cycles from the
// accepting edge, with a one-cycle done strobe.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cbrt_iter_if slave (start, x in; root, remainder, busy, done out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module cbrt_iter
    import cbrt_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    cbrt_iter_if.slave  bus
);
    localparam int unsigned R  = cbrt_root_w(W);
    localparam int unsigned CW = 3 * R;
    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

    state_t        r_state;
    logic [W-1:0]  r_x;
    logic [R-1:0]  r_root;
    logic [W-1:0]  r_rem;
    logic [IW-1:0] r_idx;
    logic          r_busy;
    logic          r_done;

    logic [R-1:0]  w_trial;
    logic [CW-1:0] w_trial_cube;
    logic [CW-1:0] w_root_cube;
    logic [CW-1:0] w_x_ext;

    // Candidate root with the current bit set
    assign w_trial = r_root | (R'(1) << r_idx);
    assign w_x_ext = CW'(r_x);

    int_cube #(.R(R)) u_trial_cube (
        .i_a    (w_trial),
        .o_cube (w_trial_cube)
    );

    int_cube #(.R(R)) u_root_cube (
        .i_a    (r_root),
        .o_cube (w_root_cube)
    );

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_x     <= bus.x;
                        r_root  <= '0;
                        r_idx   <= IW'(R - 1);
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    // Keep the bit only if the cube does not overshoot x
                    if (w_trial_cube <= w_x_ext) begin
                        r_root <= w_trial;
                    end
                    if (r_idx == '0) begin
                        r_state <= FIN;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                FIN: begin
                    // root^3 <= x, so the difference fits in W bits
                    r_rem   <= W'(w_x_ext - w_root_cube);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.root      = r_root;
    assign bus.remainder = r_rem;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule : cbrt_iter

// File: tb/tb_cbrt_iter.sv
// -----------------------------------------------------------------------------
// tb_cbrt_iter
// Directed bench for cbrt_iter at W=8 and W=16, plus a power->root loopback
// through an int_cube instance acting as the cube-power unit.
// -----------------------------------------------------------------------------
module tb_cbrt_iter;
    import cbrt_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    cbrt_iter_if #(.W(8))  bus8 ();
    cbrt_iter_if #(.W(16)) bus16 ();

    cbrt_iter #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    cbrt_iter #(.W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    logic [2:0] pow_base;
    logic [8:0] pow_out;

    int_cube #(.R(3)) u_pow (
        .i_a    (pow_base),
        .o_cube (pow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: linear search for the largest r with r^3 <= x
    task automatic cbrt_model(input int xv, output int r, output int rem);
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= xv) r++;
        rem = xv - r * r * r;
    endtask

    // Issue one request on the W=8 unit and wait (bounded) for done.
    // Called and returns at posedge+1.
    task automatic op8(input logic [7:0] xv, output int lat, output int bc);
        bus8.x     = xv;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bc  = bus8.busy ? 1 : 0;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus8.busy) bc++;
        end
        if (!bus8.done) check_eq("timeout8", 32'd0, 32'd1);
    endtask

    task automatic op16(input logic [15:0] xv, output int lat);
        bus16.x     = xv;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        lat = 0;
        while (!bus16.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus16.done) check_eq("timeout16", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, bc, r, rem, dcnt, droot, drem;
        logic [7:0] sweep_x    [6] = '{8'd0, 8'd1, 8'd63, 8'd64, 8'd125, 8'd255};
        int         sweep_root [6] = '{0, 1, 3, 4, 5, 6};
        int         sweep_rem  [6] = '{0, 0, 36, 0, 0, 39};

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus8.start  = 1'b0;
        bus8.x      = '0;
        bus16.start = 1'b0;
        bus16.x     = '0;
        pow_base    = 3'd0;

        #12;
        check_eq("rst_root",  32'(bus8.root), 32'd0);
        check_eq("rst_rem",   32'(bus8.remainder), 32'd0);
        check_eq("rst_busy",  32'(bus8.busy), 32'd0);
        check_eq("rst_done",  32'(bus8.done), 32'd0);
        check_eq("rst_busy16", 32'(bus16.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // x=27: latency, busy span, single-cycle done
        op8(8'd27, lat, bc);
        check_eq("x27_root", 32'(bus8.root), 32'd3);
        check_eq("x27_rem",  32'(bus8.remainder), 32'd0);
        check_eq("x27_lat",  32'(lat), 32'd4);
        check_eq("x27_busy_cycles", 32'(bc), 32'd4);
        check_eq("x27_busy_at_done", 32'(bus8.busy), 32'd0);
        @(posedge clk); #1;
        check_eq("x27_done_drop", 32'(bus8.done), 32'd0);
        check_eq("x27_root_hold", 32'(bus8.root), 32'd3);

        // Boundary sweep
        for (int k = 0; k < 6; k++) begin
            op8(sweep_x[k], lat, bc);
            check_eq("sweep_root", 32'(bus8.root), 32'(sweep_root[k]));
            check_eq("sweep_rem",  32'(bus8.remainder), 32'(sweep_rem[k]));
        end

        // Exhaustive W=8, back-to-back (each start lands in the done cycle)
        for (int v = 0; v < 256; v++) begin
            op8(8'(v), lat, bc);
            cbrt_model(v, r, rem);
            check_eq("exh_root", 32'(bus8.root), 32'(r));
            check_eq("exh_rem",  32'(bus8.remainder), 32'(rem));
        end
        check_eq("exh_lat", 32'(lat), 32'd4);
        @(posedge clk); #1;

        // W=16 corners
        op16(16'd65535, lat);
        check_eq("w16_max_root", 32'(bus16.root), 32'd40);
        check_eq("w16_max_rem",  32'(bus16.remainder), 32'd1535);
        check_eq("w16_lat",      32'(lat), 32'd7);
        op16(16'd64000, lat);
        check_eq("w16_64000_root", 32'(bus16.root), 32'd40);
        check_eq("w16_64000_rem",  32'(bus16.remainder), 32'd0);
        @(posedge clk); #1;

        // start pulsed while busy, x changed after acceptance: one done only
        bus8.x     = 8'd27;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        dcnt = 0; droot = 0; drem = 0;
        for (int k = 0; k < 12; k++) begin
            bus8.start = (k < 3) ? ((k % 2) == 0) : 1'b0;
            bus8.x     = 8'd255;
            @(posedge clk); #1;
            if (bus8.done) begin
                dcnt++;
                droot = 32'(bus8.root);
                drem  = 32'(bus8.remainder);
            end
        end
        check_eq("pulse_done_count", 32'(dcnt), 32'd1);
        check_eq("pulse_root", 32'(droot), 32'd3);
        check_eq("pulse_rem",  32'(drem), 32'd0);
        check_eq("pulse_idle", 32'(bus8.busy), 32'd0);

        // start held through the done cycle: immediate restart
        bus8.x     = 8'd27;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("hold_first_root", 32'(bus8.root), 32'd3);
        check_eq("hold_first_lat",  32'(lat), 32'd4);
        bus8.x = 8'd64;
        @(posedge clk); #1;
        check_eq("hold_nogap_busy", 32'(bus8.busy), 32'd1);
        check_eq("hold_nogap_done", 32'(bus8.done), 32'd0);
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("hold_second_root", 32'(bus8.root), 32'd4);
        check_eq("hold_second_rem",  32'(bus8.remainder), 32'd0);
        check_eq("hold_second_lat",  32'(lat), 32'd4);
        @(posedge clk); #1;

        // Leave a nonzero remainder, then abort a request in its 2nd CALC cycle
        op8(8'd63, lat, bc);
        check_eq("pre_abort_rem", 32'(bus8.remainder), 32'd36);
        @(posedge clk); #1;
        bus8.x     = 8'd125;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_busy_before", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_root", 32'(bus8.root), 32'd0);
        check_eq("abort_rem",  32'(bus8.remainder), 32'd0);
        check_eq("abort_busy", 32'(bus8.busy), 32'd0);
        check_eq("abort_done", 32'(bus8.done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) dcnt++;
        end
        check_eq("abort_no_done", 32'(dcnt), 32'd0);
        op8(8'd8, lat, bc);
        check_eq("after_abort_root", 32'(bus8.root), 32'd2);
        check_eq("after_abort_rem",  32'(bus8.remainder), 32'd0);
        @(posedge clk); #1;

        // Power -> root loopback
        pow_base = 3'd5;
        #1;
        check_eq("loop_pow", 32'(pow_out), 32'd125);
        op8(8'(pow_out), lat, bc);
        check_eq("loop_root", 32'(bus8.root), 32'd5);
        check_eq("loop_rem",  32'(bus8.remainder), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cbrt_iter

// File: doc/cbrt_iter.md
# cbrt_iter

Iterative integer cube root unit, the inverse of the team's iterative cube-power block. It takes a W-bit unsigned radicand and produces floor(cbrt(x)) and the remainder x − root³. It uses one root bit per cycle, with a start/busy/done handshake. It sits beside the power unit in the arithmetic datapath; a power→root loopback is the reference self-check.

## Interface

Parameters:
- W, default 8: radicand width in bits, with W ≥ 3.
- R, derived as (W+2)/3 and not overridable: root width, which is also the iteration count.

Ports:
- clk, input, 1 bit: the single clock; all state updates on the rising edge.
- rst_n, input, 1 bit: reset, asynchronous and active-low.
- start, input, 1 bit: request; sampled only in IDLE.
- x, input, W bits: unsigned radicand, sampled on the accepting edge.
- root, output, R bits: floor(cbrt(x)); valid while done=1.
- remainder, output, W bits: x − root³; valid while done=1.
- busy, output, 1 bit: high whenever the state is not IDLE.
- done, output, 1 bit: one-cycle result strobe.

## Operation

- Reset values: root, remainder, busy and done are 0; the state is IDLE. The internal radicand and bit index are also 0.
- FSM states are IDLE, CALC and FIN.
- IDLE with start=1:
  - Latch x.
  - Clear root to 0.
  - Set bit index i=R−1.
  - Move to CALC.
- IDLE with start=0: hold. root and remainder keep the last result.
- CALC, one root bit per cycle:
  - trial = root | (1<<i).
  - Compute cube = trial³ at 3R-bit width; no truncation.
  - If cube ≤ zero-extended x, then root ← trial.
  - If i==0, go to FIN; otherwise i ← i−1.
- FIN:
  - remainder ← x − root³; this result always fits in W bits.
  - done ← 1.
  - Move to IDLE.
- done is cleared on the next edge, unconditionally.
- start while busy=1 is ignored; no queuing.
- start while done=1 (state already IDLE) is accepted. done drops on that same edge.
- x changes after acceptance have no effect.
- rst_n asserted mid-operation:
  - Immediate return to IDLE with all outputs zeroed.
  - No done is produced for the aborted request.
- root carries partial values during CALC; consumers qualify it with done.

## Timing

- Start accepted at edge E0.
- Root bits are decided at edges E1..ER.
- FIN occupies the cycle after ER. remainder and done are registered at edge E(R+1).
- done is high for exactly one cycle, following E(R+1): latency R+1 cycles from the accepting edge. For W=8 this is 4 cycles.
- busy:
  - Rises after E0.
  - Falls after E(R+1), the same edge that raises done.
  - Spans R+1 cycles.
- Back-to-back throughput: one result per R+1 cycles, with start held or re-asserted in the done cycle.
- Outputs are registered only; no combinational path exists from start or x to any output.

## Structure

- Package cbrt_pkg holds:
  - The state enum (IDLE, CALC, FIN).
  - A constant function returning R for a given W.
- Sub-module int_cube:
  - Combinational, R-bit input, 3R-bit output of the input cubed.
  - Instance for the trial comparison: trial³.
  - Instance for the remainder: root³.
  - Sharing one instance via a mux is permitted.

## Test plan

- W=8, x=27 → root=3, remainder=0. done 4 cycles after the start edge; busy high for exactly 4 cycles.
- W=8, sweep x=0,1,63,64,125,255 → (0,0), (1,0), (3,36), (4,0), (5,0), (6,39). Also exhaustively check all 256 values against a model.
- W=16, x=65535 → root=40, remainder=1535. x=64000 → root=40, remainder=0.
- start pulsed every cycle during busy → ignored; exactly one done per accepted start. start held through the done cycle → a new computation starts immediately with no idle gap.
- rst_n low in the 2nd CALC cycle → outputs 0 and state IDLE asynchronously. No done follows. A subsequent start with x=8 gives root=2, remainder=0.
- Loopback: cube-power unit output for x=5 (125) fed into cbrt_iter → root=5, remainder=0.
